bus_arbiter_n: RTL and testbench

Parametrised N-port bus arbiter that sits between several bus masters (CPU fetch, CPU data, DMA, video and similar) and one shared system bus. It accepts one request at a time and drives the shared bus from registered outputs, so the bus side is glitch-free. The arbitration policy is selectable: fixed priority or round-robin. An optional watchdog aborts transactions that the target never acknowledges.

---
 rtl/bus_arbiter_n_if.sv | 34 +++
 rtl/bus_arbiter_n.sv | 142 ++++++++++++++
 tb/tb_bus_arbiter_n.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_n_if.sv
// Bundle of shared-bus and per-port master signals for bus_arbiter_n.
// The master modport is the arbiter's view; slave is the environment's view.
interface bus_arbiter_n_if #(
    parameter int unsigned PORTS = 4
);
    logic                    o_bus_rw;
    logic                    o_bus_request;
    logic                    i_bus_ready;
    logic [31:0]             o_bus_address;
    logic [31:0]             i_bus_rdata;
    logic [31:0]             o_bus_wdata;
    logic [PORTS-1:0]        i_request;
    logic [PORTS-1:0]        i_rw;
    logic [32*PORTS-1:0]     i_address;
    logic [32*PORTS-1:0]     i_wdata;
    logic [PORTS-1:0]        o_ready;
    logic [31:0]             o_rdata;
    logic [PORTS-1:0]        o_busy;
    logic [PORTS-1:0]        o_error;

    modport master (
        output o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
        input  i_bus_ready, i_bus_rdata,
        input  i_request, i_rw, i_address, i_wdata,
        output o_ready, o_rdata, o_busy, o_error
    );

    modport slave (
        input  o_bus_rw, o_bus_request, o_bus_address, o_bus_wdata,
        output i_bus_ready, i_bus_rdata,
        output i_request, i_rw, i_address, i_wdata,
        input  o_ready, o_rdata, o_busy, o_error
    );
endinterface

// File: rtl/bus_arbiter_n.sv
// N-port arbiter onto one shared bus, fixed-priority or round-robin, registered bus side.
// Optional transaction watchdog enabled by defining BUS_ARBITER_TIMEOUT_EN.
module bus_arbiter_n #(
    parameter int unsigned PORTS       = 4,
    parameter int unsigned ROUND_ROBIN = 1,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic          i_clock,
    input  logic          i_reset,
    bus_arbiter_n_if.master bus
);
    localparam int unsigned GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic [GW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             bus_rw_q, bus_rw_d;
    logic [31:0]      bus_address_q, bus_address_d;
    logic [31:0]      bus_wdata_q, bus_wdata_d;

    logic [PORTS-1:0][31:0] addr_arr;
    logic [PORTS-1:0][31:0] wdata_arr;
    logic [GW-1:0]    base_c;
    logic [GW-1:0]    winner_c;
    logic [GW-1:0]    grant_inc_c;
    logic             found_c;
    logic             timeout_c;
    logic             done_c;
    int unsigned      scan_idx;

    assign addr_arr  = bus.i_address;
    assign wdata_arr = bus.i_wdata;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]    wd_cnt_q, wd_cnt_d;
    assign timeout_c = (state_q == ACTIVE) && !bus.i_bus_ready && (wd_cnt_q == CW'(TIMEOUT));
`else
    assign timeout_c = 1'b0;
`endif

    assign done_c      = (state_q == ACTIVE) && (bus.i_bus_ready || timeout_c);
    assign grant_inc_c = (grant_q == GW'(PORTS - 1)) ? '0 : grant_q + GW'(1);
    assign base_c      = (ROUND_ROBIN != 0) ? rr_ptr_q : '0;

    // Scan upward from the base index with wrap; first requester wins
    always_comb begin
        winner_c = '0;
        found_c  = 1'b0;
        scan_idx = 0;
        for (int unsigned off = 0; off < PORTS; off++) begin
            scan_idx = 32'(base_c) + off;
            if (scan_idx >= PORTS) scan_idx = scan_idx - PORTS;
            if (!found_c && bus.i_request[GW'(scan_idx)]) begin
                found_c  = 1'b1;
                winner_c = GW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        bus_rw_d      = bus_rw_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
        wd_cnt_d      = wd_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d       = ACTIVE;
                    grant_d       = winner_c;
                    bus_rw_d      = bus.i_rw[winner_c];
                    bus_address_d = addr_arr[winner_c];
                    bus_wdata_d   = wdata_arr[winner_c];
`ifdef BUS_ARBITER_TIMEOUT_EN
                    wd_cnt_d      = '0;
`endif
                end
            end
            ACTIVE: begin
                if (done_c) begin
                    state_d = IDLE;
                    if (ROUND_ROBIN != 0) rr_ptr_d = grant_inc_c;
                end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
                    wd_cnt_d = wd_cnt_q + CW'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            bus_rw_q      <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            wd_cnt_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            bus_rw_q      <= bus_rw_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
`ifdef BUS_ARBITER_TIMEOUT_EN
            wd_cnt_q      <= wd_cnt_d;
`endif
        end
    end

    assign bus.o_bus_rw      = bus_rw_q;
    assign bus.o_bus_request = (state_q == ACTIVE);
    assign bus.o_bus_address = bus_address_q;
    assign bus.o_bus_wdata   = bus_wdata_q;

    // Port-side strobes follow the target's ready with no added latency
    always_comb begin
        bus.o_busy  = '0;
        bus.o_ready = '0;
        bus.o_error = '0;
        bus.o_rdata = bus.i_bus_rdata;
        if (state_q == ACTIVE) bus.o_busy[grant_q] = 1'b1;
        if (done_c) bus.o_ready[grant_q] = bus.i_request[grant_q];
        if (timeout_c) begin
            bus.o_error[grant_q] = bus.i_request[grant_q];
            bus.o_rdata          = '0;
        end
    end
endmodule

// File: tb/tb_bus_arbiter_n.sv
// Self-checking bench for bus_arbiter_n: round-robin and fixed-priority instances.
module tb_bus_arbiter_n;
    localparam int unsigned P = 4;

    typedef struct {
        int          port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        int          port;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        logic [31:0] rdata;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_arbiter_n_if #(.PORTS(P)) bif();
    bus_arbiter_n_if #(.PORTS(P)) bif_fp();

    bus_arbiter_n #(.PORTS(P), .ROUND_ROBIN(1), .TIMEOUT(8)) dut (
        .i_clock(clk), .i_reset(rst), .bus(bif)
    );
    bus_arbiter_n #(.PORTS(P), .ROUND_ROBIN(0), .TIMEOUT(8)) dut_fp (
        .i_clock(clk), .i_reset(rst), .bus(bif_fp)
    );

    assign bif_fp.i_request   = bif.i_request;
    assign bif_fp.i_rw        = bif.i_rw;
    assign bif_fp.i_address   = bif.i_address;
    assign bif_fp.i_wdata     = bif.i_wdata;
    assign bif_fp.i_bus_ready = bif.i_bus_ready;
    assign bif_fp.i_bus_rdata = bif.i_bus_rdata;

    exp_t q_rr[$];
    exp_t q_fp[$];
    bit   rr_mon = 1'b1;
    bit   fp_mon = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic rw, input logic [31:0] a, input logic [31:0] w);
        bif.i_rw[p]               = rw;
        bif.i_address[32*p +: 32] = a;
        bif.i_wdata[32*p +: 32]   = w;
    endtask

    // Scoreboard for the round-robin instance: each o_ready pops one expectation
    always @(negedge clk) begin : mon_rr
        exp_t e;
        if (!rst && rr_mon && bif.o_ready != '0) begin
            if (q_rr.size() == 0) begin
                check("rr_unexpected_ready", 32'(bif.o_ready), 32'(0));
            end else begin
                e = q_rr.pop_front();
                check("ready_port", 32'(bif.o_ready), 32'(1) << e.port);
                check("rdata", bif.o_rdata, e.rdata);
                check("error", 32'(bif.o_error), e.err ? (32'(1) << e.port) : 32'(0));
                check("bus_addr", bif.o_bus_address, e.addr);
                check("bus_rw", 32'(bif.o_bus_rw), 32'(e.rw));
                check("bus_wdata", bif.o_bus_wdata, e.wdata);
            end
        end
    end

    always @(negedge clk) begin : mon_fp
        exp_t e;
        if (!rst && fp_mon && bif_fp.o_ready != '0) begin
            if (q_fp.size() == 0) begin
                check("fp_unexpected_ready", 32'(bif_fp.o_ready), 32'(0));
            end else begin
                e = q_fp.pop_front();
                check("fp_ready_port", 32'(bif_fp.o_ready), 32'(1) << e.port);
                check("fp_bus_addr", bif_fp.o_bus_address, e.addr);
            end
        end
    end

    task automatic do_txn(input int p, input logic rw, input logic [31:0] a,
                          input logic [31:0] w, input int waits, input logic [31:0] rd);
        exp_t e;
        e = '{p, rw, a, w, rd, 1'b0};
        set_port(p, rw, a, w);
        bif.i_request[p] = 1'b1;
        q_rr.push_back(e);
        tick();
        check("txn_request", 32'(bif.o_bus_request), 32'(1));
        check("txn_addr", bif.o_bus_address, a);
        check("txn_rw", 32'(bif.o_bus_rw), 32'(rw));
        check("txn_busy", 32'(bif.o_busy), 32'(1) << p);
        bif.i_bus_rdata = rd;
        repeat (waits) tick();
        check("txn_addr_hold", bif.o_bus_address, a);
        check("txn_busy_hold", 32'(bif.o_busy), 32'(1) << p);
        bif.i_bus_ready = 1'b1;
        tick();
        bif.i_bus_ready  = 1'b0;
        bif.i_request[p] = 1'b0;
        check("txn_idle_after", 32'(bif.o_bus_request), 32'(0));
        check("txn_busy_after", 32'(bif.o_busy), 32'(0));
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        vec_t vecs[5];
        int   hold;
        int   cyc;
        int   ep;
        exp_t e;

        vecs[0] = '{2, 1'b0, 32'h0000_1000, 32'h0,         3, 32'hCAFE_F00D};
        vecs[1] = '{0, 1'b1, 32'h0000_0020, 32'h0000_0055, 0, 32'h0000_0000};
        vecs[2] = '{1, 1'b1, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 1, 32'h0000_0000};
        vecs[3] = '{3, 1'b0, 32'h8000_0000, 32'h0,         0, 32'h1234_5678};
        vecs[4] = '{2, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 5, 32'h0000_0000};

        rst             = 1'b1;
        bif.i_request   = '0;
        bif.i_rw        = '0;
        bif.i_address   = '0;
        bif.i_wdata     = '0;
        bif.i_bus_ready = 1'b0;
        bif.i_bus_rdata = '0;
        repeat (2) tick();
        check("rst_request", 32'(bif.o_bus_request), 32'(0));
        check("rst_busy", 32'(bif.o_busy), 32'(0));
        check("rst_addr", bif.o_bus_address, 32'(0));
        check("rst_wdata", bif.o_bus_wdata, 32'(0));
        check("rst_rw", 32'(bif.o_bus_rw), 32'(0));
        check("rst_ready", 32'(bif.o_ready), 32'(0));
        check("rst_error", 32'(bif.o_error), 32'(0));
        rst = 1'b0;
        tick();

        // Ready strobe while idle must be ignored
        bif.i_bus_ready = 1'b1;
        bif.i_bus_rdata = 32'h1111_2222;
        tick();
        check("idle_ready_ignored", 32'(bif.o_ready), 32'(0));
        check("idle_no_request", 32'(bif.o_bus_request), 32'(0));
        bif.i_bus_ready = 1'b0;
        tick();

        // Round-robin with all ports requesting: 0,1,2,3,0, one idle cycle apart
        for (int k = 0; k < 4; k++)
            set_port(k, (k % 2) == 1, 32'h100 * (k + 1), 32'h1111_0000 + k);
        for (int t = 0; t < 5; t++) begin
            ep = t % 4;
            e  = '{ep, (ep % 2) == 1, 32'h100 * (ep + 1), 32'h1111_0000 + ep, 32'hA0 + ep, 1'b0};
            q_rr.push_back(e);
        end
        bif.i_request = 4'hF;
        tick();
        for (int t = 0; t < 5; t++) begin
            ep = t % 4;
            check("rr_busy", 32'(bif.o_busy), 32'(1) << ep);
            bif.i_bus_rdata = 32'hA0 + ep;
            bif.i_bus_ready = 1'b1;
            tick();
            bif.i_bus_ready = 1'b0;
            if (t == 4) bif.i_request = '0;
            check("rr_gap", 32'(bif.o_bus_request), 32'(0));
            tick();
        end

        for (int i = 0; i < 5; i++)
            do_txn(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].waits, vecs[i].rdata);

        // Port 0 withdraws mid-transaction: bus completes, no o_ready
        set_port(0, 1'b1, 32'h20, 32'h55);
        bif.i_request[0] = 1'b1;
        tick();
        check("wd_addr", bif.o_bus_address, 32'h20);
        check("wd_wdata", bif.o_bus_wdata, 32'h55);
        check("wd_rw", 32'(bif.o_bus_rw), 32'(1));
        bif.i_request[0] = 1'b0;
        repeat (2) tick();
        check("wd_still_active", 32'(bif.o_bus_request), 32'(1));
        bif.i_bus_ready = 1'b1;
        #1;
        check("wd_ready_suppressed", 32'(bif.o_ready), 32'(0));
        tick();
        bif.i_bus_ready = 1'b0;
        check("wd_idle", 32'(bif.o_bus_request), 32'(0));
        do_txn(1, 1'b0, 32'h44, 32'h0, 1, 32'h7777_0001);

        // Fixed priority: ports 1 and 3 hold requests, 1 wins until it drops
        rr_mon = 1'b0;
        fp_mon = 1'b1;
        set_port(1, 1'b0, 32'h1100, 32'h0);
        set_port(3, 1'b1, 32'h3300, 32'h33);
        for (int t = 0; t < 4; t++) begin
            ep = (t < 3) ? 1 : 3;
            e  = '{ep, 1'b0, (ep == 1) ? 32'h1100 : 32'h3300, 32'h0, 32'h0, 1'b0};
            q_fp.push_back(e);
        end
        bif.i_request = 4'b1010;
        tick();
        for (int t = 0; t < 4; t++) begin
            ep = (t < 3) ? 1 : 3;
            check("fp_busy", 32'(bif_fp.o_busy), 32'(1) << ep);
            bif.i_bus_ready = 1'b1;
            tick();
            bif.i_bus_ready = 1'b0;
            if (t == 2) bif.i_request[1] = 1'b0;
            if (t == 3) bif.i_request[3] = 1'b0;
            check("fp_gap", 32'(bif_fp.o_bus_request), 32'(0));
            tick();
        end
        fp_mon = 1'b0;
        rr_mon = 1'b1;

        // Unresponsive target on port 1
        set_port(1, 1'b0, 32'h3000, 32'h0);
        bif.i_request[1] = 1'b1;
        bif.i_bus_rdata  = 32'hBAD0_BAD0;
`ifdef BUS_ARBITER_TIMEOUT_EN
        e = '{1, 1'b0, 32'h3000, 32'h0, 32'h0, 1'b1};
        q_rr.push_back(e);
        tick();
        cyc = 1;
        while (bif.o_ready == '0 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("timeout_cycle", 32'(cyc), 32'(9));
        tick();
        bif.i_request[1] = 1'b0;
        check("timeout_idle", 32'(bif.o_bus_request), 32'(0));
`else
        e = '{1, 1'b0, 32'h3000, 32'h0, 32'h600D_600D, 1'b0};
        q_rr.push_back(e);
        tick();
        hold = 0;
        repeat (100) begin
            if (bif.o_bus_request && bif.o_ready == '0 && bif.o_error == '0) hold++;
            tick();
        end
        check("no_timeout_hold", 32'(hold), 32'(100));
        bif.i_bus_rdata = 32'h600D_600D;
        bif.i_bus_ready = 1'b1;
        tick();
        bif.i_bus_ready  = 1'b0;
        bif.i_request[1] = 1'b0;
        check("late_ready_idle", 32'(bif.o_bus_request), 32'(0));
`endif
        tick();

        // Reset during a port-3 transaction abandons it and restarts round-robin
        set_port(3, 1'b0, 32'h3333_0000, 32'h0);
        bif.i_request[3] = 1'b1;
        tick();
        check("rst_mid_busy_before", 32'(bif.o_busy), 32'(8));
        rst = 1'b1;
        tick();
        check("rst_mid_request", 32'(bif.o_bus_request), 32'(0));
        check("rst_mid_busy", 32'(bif.o_busy), 32'(0));
        check("rst_mid_addr", bif.o_bus_address, 32'(0));
        rst              = 1'b0;
        bif.i_request[3] = 1'b0;
        tick();
        set_port(0, 1'b0, 32'h0A00, 32'h0);
        set_port(2, 1'b0, 32'h2A00, 32'h0);
        e = '{0, 1'b0, 32'h0A00, 32'h0, 32'h0000_00C0, 1'b0};
        q_rr.push_back(e);
        e = '{2, 1'b0, 32'h2A00, 32'h0, 32'h0000_00C2, 1'b0};
        q_rr.push_back(e);
        bif.i_request = 4'b0101;
        tick();
        check("restart_port0", 32'(bif.o_busy), 32'(1));
        bif.i_bus_rdata = 32'h0000_00C0;
        bif.i_bus_ready = 1'b1;
        tick();
        bif.i_bus_ready  = 1'b0;
        bif.i_request[0] = 1'b0;
        tick();
        check("restart_port2", 32'(bif.o_busy), 32'(4));
        bif.i_bus_rdata = 32'h0000_00C2;
        bif.i_bus_ready = 1'b1;
        tick();
        bif.i_bus_ready = 1'b0;
        bif.i_request   = '0;
        repeat (2) tick();

        check("rr_queue_drained", 32'(q_rr.size()), 32'(0));
        check("fp_queue_drained", 32'(q_fp.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
